hazard_unit: RTL

Pipeline hazard and forwarding unit for the 5-stage MIPS core (IF, ID, EX, MEM, WB). Sits downstream of the instruction decoder's hazard outputs (re1, re2, we_bypass, we_stall). It tracks destination registers of in-flight instructions in a private scoreboard and produces two signals:
- a load-use stall toward IF/ID;
- registered operand-forwarding selects consumed by the EX-stage operand muxes.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_sb_stage.sv | 20 ++
 rtl/hazard_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding unit: register index,
// forwarding-select encodings and the scoreboard entry layout.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RET   = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     wr;
    logic     ld;
  } sb_entry_t;

  // Scoreboard slot positions, oldest last.
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_RET   = 3;
  localparam int SB_DEPTH = 4;

  // An in-flight entry produces the operand the ID instruction reads.
  function automatic logic sb_match(input sb_entry_t e, input reg_idx_t x, input logic rd_en);
    return rd_en && e.valid && e.wr && (e.dest == x) && (x != '0);
  endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard slot: holds {valid, dest, wr, ld} of the instruction
// occupying a pipeline stage; cleared by reset.
module hazard_sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection and registered EX operand-forwarding selects,
// driven by a private EX/MEM/WB/RET scoreboard of destination registers.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_dst,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             id_we_bypass,
  input  logic             id_we_stall,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_ex,
  output logic [1:0]       fwd_b_ex,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t [SB_DEPTH-1:0] sb_d;
  sb_entry_t [SB_DEPTH-1:0] sb_q;
  sb_entry_t                id_entry;
  reg_idx_t                 id_dest;
  fwd_sel_t                 sel_a;
  fwd_sel_t                 sel_b;

  assign id_dest = id_reg_dst ? id_rd : id_rt;

  assign stall = id_valid && !flush && sb_q[SB_EX].ld &&
                 (sb_match(sb_q[SB_EX], id_rs, id_re1) || sb_match(sb_q[SB_EX], id_rt, id_re2));

  always_comb begin
    id_entry       = '0;
    id_entry.valid = id_valid && !stall && !flush;
    id_entry.dest  = id_dest;
    id_entry.wr    = id_we_bypass && (id_dest != '0);
    id_entry.ld    = id_we_stall;
  end

  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
    if (gi == SB_EX) begin : g_head
      assign sb_d[gi] = id_entry;
    end else if (gi == SB_RET) begin : g_ret
      assign sb_d[gi] = '{valid: sb_q[gi-1].valid, dest: sb_q[gi-1].dest,
                          wr: sb_q[gi-1].wr, ld: 1'b0};
    end else begin : g_mid
      assign sb_d[gi] = sb_q[gi-1];
    end

    hazard_sb_stage u_stage (
      .clk (clk),
      .rst (rst),
      .d   (sb_d[gi]),
      .q   (sb_q[gi])
    );
  end

  // Nearest producer wins; a RET match means the regfile already holds the value.
  function automatic fwd_sel_t pick_fwd(input sb_entry_t ex, input sb_entry_t mem,
                                        input sb_entry_t wb, input reg_idx_t x,
                                        input logic rd_en);
    if (sb_match(ex, x, rd_en))       return FWD_EXMEM;
    else if (sb_match(mem, x, rd_en)) return FWD_MEMWB;
    else if (sb_match(wb, x, rd_en))  return FWD_RET;
    else                              return FWD_RF;
  endfunction

  always_comb begin
    sel_a = pick_fwd(sb_q[SB_EX], sb_q[SB_MEM], sb_q[SB_WB], id_rs, id_re1);
    sel_b = pick_fwd(sb_q[SB_EX], sb_q[SB_MEM], sb_q[SB_WB], id_rt, id_re2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_ex <= FWD_RF;
      fwd_b_ex <= FWD_RF;
    end else if (id_entry.valid) begin
      fwd_a_ex <= sel_a;
      fwd_b_ex <= sel_b;
    end else begin
      fwd_a_ex <= FWD_RF;
      fwd_b_ex <= FWD_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  // RET and the WB load flag are tracked for the regfile-write window only.
  logic sb_unused;
  assign sb_unused = ^{sb_q[SB_RET], sb_q[SB_WB].ld};

endmodule
